// File: rtl/prog_run_ctrl_if.sv
// -----------------------------------------------------------------------------
// prog_run_ctrl_if
//   Bundles the shared data-memory port for the run controller. It holds three
//   groups of signals: the host loader side, the processor core side, and the
//   single physical data-memory port.
//
//   modport slave  : the run controller (prog_run_ctrl)
//     in  host_req, host_we, host_addr, host_wdata
//     in  core_we, core_addr, core_wdata
//     in  mem_rdata
//     out host_gnt, host_rdata, core_rdata
//     out mem_we, mem_addr, mem_wdata
//   modport master : the surrounding system (host, core, memory), which drives
//                    the controller's inputs and receives its outputs.
// -----------------------------------------------------------------------------
interface prog_run_ctrl_if #(
   parameter int AW = 8,
   parameter int DW = 8
);
   logic          host_req;
   logic          host_we;
   logic [AW-1:0] host_addr;
   logic [DW-1:0] host_wdata;
   logic          host_gnt;
   logic [DW-1:0] host_rdata;

   logic          core_we;
   logic [AW-1:0] core_addr;
   logic [DW-1:0] core_wdata;
   logic [DW-1:0] core_rdata;

   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;

   modport slave (
      input  host_req, host_we, host_addr, host_wdata,
      input  core_we, core_addr, core_wdata,
      input  mem_rdata,
      output host_gnt, host_rdata, core_rdata,
      output mem_we, mem_addr, mem_wdata
   );

   modport master (
      output host_req, host_we, host_addr, host_wdata,
      output core_we, core_addr, core_wdata,
      output mem_rdata,
      input  host_gnt, host_rdata, core_rdata,
      input  mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/prog_run_ctrl.sv
// -----------------------------------------------------------------------------
// prog_run_ctrl
//   Run controller and data-memory arbiter for the single-cycle core.
//   It turns a rising edge on Start into a one-cycle core launch and watches
//   core_halt to detect completion. It counts the halt-free RUN cycles in
//   CycleCt. It also shares the single data-memory port: the host owns the port
//   in IDLE and DONE, and the core owns it in LAUNCH and RUN.
//
//   Optional feature: define RUN_CTRL_WATCHDOG_EN to compile in the watchdog.
//   The watchdog ends RUN with Timeout=1 after TIMEOUT halt-free cycles. When
//   the macro is not defined, Timeout is tied to 0.
//
//   Ports
//     Clk, Reset_n   : clock (posedge) and synchronous active-low reset
//     Start          : host start level. A rising edge launches a program.
//     core_halt      : core done flag
//     core_reset     : active-high reset to the core, asserted in IDLE
//     core_start     : one-cycle start pulse, asserted in LAUNCH
//     Done, Timeout  : run-finished flags, held until the next launch
//     CycleCt        : halt-free RUN cycles of the last or current run
//     bus (slave)    : host / core / data-memory port (see prog_run_ctrl_if)
// -----------------------------------------------------------------------------
module prog_run_ctrl #(
   parameter int              AW      = 8,
   parameter int              DW      = 8,
   parameter int              CW      = 16,
   parameter logic [CW-1:0]   TIMEOUT = 16'd4000
) (
   input  logic          Clk,
   input  logic          Reset_n,
   input  logic          Start,
   input  logic          core_halt,
   output logic          core_reset,
   output logic          core_start,
   output logic          Done,
   output logic          Timeout,
   output logic [CW-1:0] CycleCt,
   prog_run_ctrl_if.slave bus
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_LAUNCH = 2'd1;
   localparam logic [1:0] ST_RUN    = 2'd2;
   localparam logic [1:0] ST_DONE   = 2'd3;

   logic [1:0]    state_q, state_d;
   logic          start_q, start_d;
   logic          done_q, done_d;
   logic          timeout_q, timeout_d;
   logic [CW-1:0] cycle_ct_q, cycle_ct_d;

   logic          launch_evt;
   logic          wd_hit;
   logic          host_owns;

   logic          mem_we_d;
   logic [AW-1:0] mem_addr_d;
   logic [DW-1:0] mem_wdata_d;
   logic          host_gnt_d;

   // The edge detector runs in every state. A Start level held across the end
   // of a run therefore never looks like a new edge.
   assign start_d    = Start;
   assign launch_evt = Start & ~start_q;

`ifdef RUN_CTRL_WATCHDOG_EN
   localparam logic [CW-1:0] WD_LAST = TIMEOUT - CW'(1);
   assign wd_hit = (cycle_ct_q == WD_LAST);
`else
   logic unused_timeout;
   assign unused_timeout = ^TIMEOUT;
   assign wd_hit         = 1'b0;
`endif

   // ---------------------------------------------------------------- next state
   always_comb begin
      // NOTE: every signal assigned here first gets a default. Without the
      // defaults, branches that skip an assignment would infer latches.
      state_d    = state_q;
      done_d     = done_q;
      timeout_d  = timeout_q;
      cycle_ct_d = cycle_ct_q;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            // Clear the status on the launch edge. This way Done and Timeout
            // already read 0 during the LAUNCH cycle.
            if (launch_evt) begin
               state_d    = ST_LAUNCH;
               done_d     = 1'b0;
               timeout_d  = 1'b0;
               cycle_ct_d = '0;
            end
         end
         ST_LAUNCH: begin
            state_d    = ST_RUN;
            done_d     = 1'b0;
            timeout_d  = 1'b0;
            cycle_ct_d = '0;
         end
         ST_RUN: begin
            // Halt has priority over the watchdog in the same cycle. The
            // cycle that ends the run is not counted.
            if (core_halt) begin
               state_d = ST_DONE;
               done_d  = 1'b1;
            end else if (wd_hit) begin
               state_d   = ST_DONE;
               done_d    = 1'b1;
               timeout_d = 1'b1;
            end else if (cycle_ct_q != '1) begin
               cycle_ct_d = cycle_ct_q + CW'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // ---------------------------------------------------------------- registers
   always_ff @(posedge Clk) begin
      // NOTE: sequential state uses non-blocking assignments. Every flop then
      // samples pre-edge values, whatever order the statements are in.
      if (!Reset_n) begin
         state_q    <= ST_IDLE;
         start_q    <= 1'b0;
         done_q     <= 1'b0;
         timeout_q  <= 1'b0;
         cycle_ct_q <= '0;
      end else begin
         state_q    <= state_d;
         start_q    <= start_d;
         done_q     <= done_d;
         timeout_q  <= timeout_d;
         cycle_ct_q <= cycle_ct_d;
      end
   end

   // ---------------------------------------------------------------- core control
   assign core_reset = (state_q == ST_IDLE);
   assign core_start = (state_q == ST_LAUNCH);
   assign Done       = done_q;
   assign Timeout    = timeout_q;
   assign CycleCt    = cycle_ct_q;

   // ---------------------------------------------------------------- memory mux
   // Core writes are masked in LAUNCH because the core is only starting up.
   // A host request made while the core owns the port is dropped. The host
   // must hold it until host_gnt rises.
   assign host_owns = (state_q == ST_IDLE) || (state_q == ST_DONE);

   always_comb begin
      host_gnt_d  = 1'b0;
      mem_we_d    = 1'b0;
      mem_addr_d  = bus.core_addr;
      mem_wdata_d = bus.core_wdata;
      if (host_owns) begin
         host_gnt_d  = bus.host_req;
         mem_we_d    = bus.host_req & bus.host_we;
         mem_addr_d  = bus.host_addr;
         mem_wdata_d = bus.host_wdata;
      end else if (state_q == ST_RUN) begin
         mem_we_d = bus.core_we;
      end
   end

   assign bus.host_gnt   = host_gnt_d;
   assign bus.mem_we     = mem_we_d;
   assign bus.mem_addr   = mem_addr_d;
   assign bus.mem_wdata  = mem_wdata_d;
   assign bus.host_rdata = bus.mem_rdata;
   assign bus.core_rdata = bus.mem_rdata;

endmodule

// File: tb/tb_prog_run_ctrl.sv
// -----------------------------------------------------------------------------
// tb_prog_run_ctrl
//   Self-checking bench for prog_run_ctrl. It contains:
//     - a small data memory with asynchronous read,
//     - a table of directed single-cycle vectors,
//     - hand-written multi-cycle sequences (37-cycle run, watchdog, reset
//       mid-run),
//     - a randomized phase checked against a run-level reference model.
//   With RUN_CTRL_WATCHDOG_EN defined, the watchdog sequences run with
//   TIMEOUT=10.
// -----------------------------------------------------------------------------
module tb_prog_run_ctrl;

   localparam int AW      = 8;
   localparam int DW      = 8;
   localparam int CW      = 16;
   localparam int TIMEOUT = 10;
`ifdef RUN_CTRL_WATCHDOG_EN
   localparam bit WD_ON    = 1'b1;
   localparam int HALT_RUN = 7;
`else
   localparam bit WD_ON    = 1'b0;
   localparam int HALT_RUN = 37;
`endif

   logic          Clk;
   logic          Reset_n;
   logic          Start;
   logic          core_halt;
   logic          core_reset;
   logic          core_start;
   logic          Done;
   logic          Timeout;
   logic [CW-1:0] CycleCt;

   prog_run_ctrl_if #(.AW(AW), .DW(DW)) bus ();

   prog_run_ctrl #(
      .AW(AW), .DW(DW), .CW(CW), .TIMEOUT(16'(TIMEOUT))
   ) dut (
      .Clk        (Clk),
      .Reset_n    (Reset_n),
      .Start      (Start),
      .core_halt  (core_halt),
      .core_reset (core_reset),
      .core_start (core_start),
      .Done       (Done),
      .Timeout    (Timeout),
      .CycleCt    (CycleCt),
      .bus        (bus)
   );

   // Data memory: asynchronous read, write on posedge.
   logic [DW-1:0] dmem [256];
   assign bus.mem_rdata = dmem[bus.mem_addr];
   always @(posedge Clk) if (bus.mem_we) dmem[bus.mem_addr] <= bus.mem_wdata;

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic sample();
      @(negedge Clk);
   endtask

   task automatic drive(input logic s, h, rq, hw, input logic [7:0] ha, hd,
                        input logic cw, input logic [7:0] ca, cd);
      Start          = s;
      core_halt      = h;
      bus.host_req   = rq;
      bus.host_we    = hw;
      bus.host_addr  = ha;
      bus.host_wdata = hd;
      bus.core_we    = cw;
      bus.core_addr  = ca;
      bus.core_wdata = cd;
   endtask

   // This task expects Start to have been low on the previous edge. It returns
   // just after the edge that enters RUN cycle 1.
   task automatic launch_run();
      Start     = 1'b1;
      core_halt = 1'b0;
      sample();
      check("pre_launch_start", core_start, 1'b0);
      step();
      sample();
      check("launch_pulse", core_start, 1'b1);
      check("launch_core_reset", core_reset, 1'b0);
      step();
   endtask

   typedef struct {
      string      nm;
      logic       s, h, rq, hw;
      logic [7:0] ha, hd;
      logic       cw;
      logic [7:0] ca, cd;
      logic       e_cr, e_cs, e_gnt, e_mwe;
      logic [7:0] e_ma;
      logic       e_done;
      logic [15:0] e_ct;
      logic       chk_rd;
      logic [7:0] e_rd;
   } vec_t;

   function automatic vec_t mk(string nm, logic s, h, rq, hw, logic [7:0] ha, hd,
                               logic cw, logic [7:0] ca, cd,
                               logic ecr, ecs, eg, emw, logic [7:0] ema,
                               logic ed, logic [15:0] ect, logic crd, logic [7:0] erd);
      vec_t v;
      v.nm = nm; v.s = s; v.h = h; v.rq = rq; v.hw = hw; v.ha = ha; v.hd = hd;
      v.cw = cw; v.ca = ca; v.cd = cd;
      v.e_cr = ecr; v.e_cs = ecs; v.e_gnt = eg; v.e_mwe = emw; v.e_ma = ema;
      v.e_done = ed; v.e_ct = ect; v.chk_rd = crd; v.e_rd = erd;
      return v;
   endfunction

   // Reference model state, kept at the level of "is a run in progress".
   bit m_ran, m_running, m_first, m_done, m_to, m_prev;
   int m_ct;

   initial begin
      vec_t vq[$];

      // ------------------------------------------------------------ reset
      Reset_n = 1'b0;
      drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 8'h77, 8'h00);
      step();
      sample();
      check("rst_core_reset", core_reset, 1'b1);
      check("rst_core_start", core_start, 1'b0);
      check("rst_host_gnt", bus.host_gnt, 1'b1);
      check("rst_mem_addr", bus.mem_addr, 8'h10);
      check("rst_done", Done, 1'b0);
      check("rst_timeout", Timeout, 1'b0);
      check("rst_cycle_ct", CycleCt, 16'd0);
      step();
      Reset_n = 1'b1;

      // ------------------------------------------------------------ table
      //                  nm              s  h  rq hw ha     hd     cw ca     cd     cr cs g  mwe ma    d  ct     crd rd
      vq.push_back(mk("idle_wr",      1'b0,1'b0,1'b1,1'b1,8'h20,8'hA5,1'b1,8'h33,8'h00,1'b1,1'b0,1'b1,1'b1,8'h20,1'b0,16'd0,1'b0,8'h00));
      vq.push_back(mk("start_rise",   1'b1,1'b0,1'b0,1'b0,8'h20,8'h00,1'b0,8'h40,8'h00,1'b1,1'b0,1'b0,1'b0,8'h20,1'b0,16'd0,1'b1,8'hA5));
      vq.push_back(mk("launch",       1'b1,1'b0,1'b1,1'b1,8'h55,8'hEE,1'b1,8'h40,8'h77,1'b0,1'b1,1'b0,1'b0,8'h40,1'b0,16'd0,1'b0,8'h00));
      vq.push_back(mk("run1",         1'b1,1'b0,1'b1,1'b1,8'h55,8'hEE,1'b1,8'h41,8'h11,1'b0,1'b0,1'b0,1'b1,8'h41,1'b0,16'd0,1'b0,8'h00));
      vq.push_back(mk("run2",         1'b1,1'b0,1'b1,1'b0,8'h20,8'h00,1'b0,8'h20,8'h00,1'b0,1'b0,1'b0,1'b0,8'h20,1'b0,16'd1,1'b1,8'hA5));
      vq.push_back(mk("run_halt",     1'b1,1'b1,1'b1,1'b0,8'h20,8'h00,1'b0,8'h20,8'h00,1'b0,1'b0,1'b0,1'b0,8'h20,1'b0,16'd2,1'b1,8'hA5));
      vq.push_back(mk("done_rd",      1'b1,1'b1,1'b1,1'b0,8'h20,8'h00,1'b1,8'h41,8'h99,1'b0,1'b0,1'b1,1'b0,8'h20,1'b1,16'd2,1'b1,8'hA5));
      vq.push_back(mk("done_rd2",     1'b1,1'b0,1'b1,1'b0,8'h41,8'h00,1'b1,8'h20,8'h99,1'b0,1'b0,1'b1,1'b0,8'h41,1'b1,16'd2,1'b1,8'h11));
      vq.push_back(mk("start_low",    1'b0,1'b0,1'b0,1'b0,8'h41,8'h00,1'b0,8'h20,8'h00,1'b0,1'b0,1'b0,1'b0,8'h41,1'b1,16'd2,1'b1,8'h11));
      vq.push_back(mk("start_rise2",  1'b1,1'b0,1'b0,1'b0,8'h41,8'h00,1'b0,8'h20,8'h00,1'b0,1'b0,1'b0,1'b0,8'h41,1'b1,16'd2,1'b0,8'h00));
      vq.push_back(mk("relaunch",     1'b1,1'b0,1'b1,1'b1,8'h41,8'hCC,1'b1,8'h42,8'h33,1'b0,1'b1,1'b0,1'b0,8'h42,1'b0,16'd0,1'b0,8'h00));
      vq.push_back(mk("run_a",        1'b1,1'b0,1'b0,1'b0,8'h41,8'h00,1'b0,8'h42,8'h00,1'b0,1'b0,1'b0,1'b0,8'h42,1'b0,16'd0,1'b0,8'h00));
      vq.push_back(mk("run_b",        1'b1,1'b1,1'b0,1'b0,8'h41,8'h00,1'b0,8'h42,8'h00,1'b0,1'b0,1'b0,1'b0,8'h42,1'b0,16'd1,1'b0,8'h00));
      vq.push_back(mk("done2",        1'b0,1'b0,1'b1,1'b0,8'h20,8'h00,1'b0,8'h42,8'h00,1'b0,1'b0,1'b1,1'b0,8'h20,1'b1,16'd1,1'b1,8'hA5));

      foreach (vq[i]) begin
         drive(vq[i].s, vq[i].h, vq[i].rq, vq[i].hw, vq[i].ha, vq[i].hd,
               vq[i].cw, vq[i].ca, vq[i].cd);
         sample();
         check({vq[i].nm, ".core_reset"}, core_reset, vq[i].e_cr);
         check({vq[i].nm, ".core_start"}, core_start, vq[i].e_cs);
         check({vq[i].nm, ".host_gnt"}, bus.host_gnt, vq[i].e_gnt);
         check({vq[i].nm, ".mem_we"}, bus.mem_we, vq[i].e_mwe);
         check({vq[i].nm, ".mem_addr"}, bus.mem_addr, vq[i].e_ma);
         check({vq[i].nm, ".done"}, Done, vq[i].e_done);
         check({vq[i].nm, ".timeout"}, Timeout, 1'b0);
         check({vq[i].nm, ".cycle_ct"}, CycleCt, vq[i].e_ct);
         if (vq[i].chk_rd) begin
            check({vq[i].nm, ".host_rdata"}, bus.host_rdata, vq[i].e_rd);
            check({vq[i].nm, ".core_rdata"}, bus.core_rdata, vq[i].e_rd);
         end
         step();
      end

      // ------------------------------------------------------------ halt after HALT_RUN cycles
      drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h20, 8'h00, 1'b0, 8'h60, 8'h00);
      launch_run();
      for (int i = 0; i < HALT_RUN; i++) begin
         sample();
         if (i == 0) check("start_one_cycle", core_start, 1'b0);
         check("run_gnt_denied", bus.host_gnt, 1'b0);
         check("run_cycle_ct", CycleCt, 16'(i));
         step();
      end
      core_halt = 1'b1;
      sample();
      check("halt_cycle_not_done", Done, 1'b0);
      step();
      core_halt = 1'b0;
      sample();
      check("halt_done", Done, 1'b1);
      check("halt_cycle_ct", CycleCt, 16'(HALT_RUN));
      check("halt_timeout", Timeout, 1'b0);
      check("halt_readback_gnt", bus.host_gnt, 1'b1);
      check("halt_readback_data", bus.host_rdata, 8'hA5);
      // Start has stayed high since the launch, so no relaunch may follow.
      for (int i = 0; i < 3; i++) begin
         step();
         sample();
         check("held_start_no_relaunch", core_start, 1'b0);
         check("held_start_done", Done, 1'b1);
      end

`ifdef RUN_CTRL_WATCHDOG_EN
      // ------------------------------------------------------------ watchdog fires
      Start = 1'b0;
      step();
      launch_run();
      begin
         int n = 0;
         for (n = 0; n < 20; n++) begin
            sample();
            if (Done) break;
            step();
         end
         check("wd_run_cycles", n, TIMEOUT);
      end
      check("wd_done", Done, 1'b1);
      check("wd_timeout", Timeout, 1'b1);
      check("wd_cycle_ct", CycleCt, 16'(TIMEOUT - 1));
      // Halt arrives in the same cycle as the watchdog limit, and halt wins.
      Start = 1'b0;
      step();
      launch_run();
      for (int i = 0; i < TIMEOUT - 1; i++) begin
         sample();
         if (i == 0) check("wd_timeout_cleared", Timeout, 1'b0);
         step();
      end
      core_halt = 1'b1;
      sample();
      check("wd_tie_ct_before", CycleCt, 16'(TIMEOUT - 1));
      step();
      core_halt = 1'b0;
      sample();
      check("wd_tie_done", Done, 1'b1);
      check("wd_tie_timeout", Timeout, 1'b0);
      check("wd_tie_cycle_ct", CycleCt, 16'(TIMEOUT - 1));
`else
      // ------------------------------------------------------------ no watchdog: run continues
      Start = 1'b0;
      step();
      launch_run();
      for (int i = 0; i < 15; i++) step();
      sample();
      check("nowd_still_running", Done, 1'b0);
      check("nowd_timeout", Timeout, 1'b0);
      check("nowd_cycle_ct", CycleCt, 16'd15);
      check("nowd_gnt", bus.host_gnt, 1'b0);
      core_halt = 1'b1;
      step();
      core_halt = 1'b0;
      sample();
      check("nowd_done", Done, 1'b1);
      check("nowd_final_ct", CycleCt, 16'd15);
`endif

      // ------------------------------------------------------------ reset mid-run
      Start = 1'b0;
      step();
      launch_run();
      for (int i = 0; i < 5; i++) step();
      sample();
      check("midrun_ct", CycleCt, 16'd5);
      Start   = 1'b0;
      Reset_n = 1'b0;
      drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h10, 8'h00, 1'b1, 8'h60, 8'h00);
      step();
      sample();
      check("midrun_rst_core_reset", core_reset, 1'b1);
      check("midrun_rst_done", Done, 1'b0);
      check("midrun_rst_ct", CycleCt, 16'd0);
      check("midrun_rst_gnt", bus.host_gnt, 1'b1);
      check("midrun_rst_mem_addr", bus.mem_addr, 8'h10);
      Reset_n = 1'b1;
      step();
      sample();
      check("after_rst_idle", core_reset, 1'b1);
      check("after_rst_no_start", core_start, 1'b0);

      // ------------------------------------------------------------ random vs model
      Reset_n = 1'b0;
      step();
      Reset_n = 1'b1;
      m_ran = 0; m_running = 0; m_first = 0; m_done = 0; m_to = 0; m_prev = 0; m_ct = 0;
      for (int c = 0; c < 400; c++) begin
         logic          e_gnt, e_mwe;
         logic [AW-1:0] e_ma;
         logic [DW-1:0] e_wd;
         Reset_n = ($urandom_range(0, 63) != 0);
         if ($urandom_range(0, 3) == 0) Start = ~Start;
         core_halt      = ($urandom_range(0, 7) == 0);
         bus.host_req   = 1'($urandom_range(0, 1));
         bus.host_we    = 1'($urandom_range(0, 1));
         bus.host_addr  = 8'($urandom_range(0, 255));
         bus.host_wdata = 8'($urandom_range(0, 255));
         bus.core_we    = 1'($urandom_range(0, 1));
         bus.core_addr  = 8'($urandom_range(0, 255));
         bus.core_wdata = 8'($urandom_range(0, 255));
         sample();

         e_gnt = !m_running && bus.host_req;
         e_mwe = m_running ? (!m_first && bus.core_we) : (bus.host_req && bus.host_we);
         e_ma  = m_running ? bus.core_addr : bus.host_addr;
         e_wd  = m_running ? bus.core_wdata : bus.host_wdata;
         check("rand_core_reset", core_reset, !m_ran);
         check("rand_core_start", core_start, m_first);
         check("rand_host_gnt", bus.host_gnt, e_gnt);
         check("rand_mem_we", bus.mem_we, e_mwe);
         check("rand_mem_addr", bus.mem_addr, e_ma);
         check("rand_mem_wdata", bus.mem_wdata, e_wd);
         check("rand_done", Done, m_done);
         check("rand_timeout", Timeout, m_to);
         check("rand_cycle_ct", CycleCt, m_ct);
         check("rand_host_rdata", bus.host_rdata, dmem[e_ma]);
         check("rand_core_rdata", bus.core_rdata, dmem[e_ma]);

         // Advance the model across the coming edge.
         if (!Reset_n) begin
            m_ran = 0; m_running = 0; m_first = 0; m_done = 0; m_to = 0; m_prev = 0; m_ct = 0;
         end else begin
            if (m_first) begin
               m_first = 0;
            end else if (m_running) begin
               if (core_halt) begin
                  m_running = 0; m_done = 1;
               end else if (WD_ON && m_ct == TIMEOUT - 1) begin
                  m_running = 0; m_done = 1; m_to = 1;
               end else if (m_ct < 65535) begin
                  m_ct++;
               end
            end else if (Start && !m_prev) begin
               m_running = 1; m_first = 1; m_ran = 1; m_done = 0; m_to = 0; m_ct = 0;
            end
            m_prev = Start;
         end
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_time_limit: simulation did not finish, limit %0t", $time);
      $fatal(1, "time limit");
   end

endmodule

// File: doc/prog_run_ctrl.md
# prog_run_ctrl

Run controller and data-memory arbiter wrapped around the single-cycle processor core. Turns a host `Start` edge into a clean core launch and watches the core's halt flag to detect completion. Counts executed cycles and, optionally, aborts runaway programs with a watchdog. Shares the single data-memory port between the host loader (idle/done phases) and the core (run phase).

## Interface
Parameters:
- `AW`, 8: data-memory address width
- `DW`, 8: data-memory data width
- `CW`, 16: cycle-counter width
- `TIMEOUT`, 16'd4000: watchdog limit in RUN cycles (used only with the watchdog compiled in)

Ports:
- `Clk`  in  1: clock; posedge only
- `Reset_n`  in  1: synchronous, active-low reset
- `Start`  in  1: host start level; a rising edge launches a program
- `host_req`  in  1: host requests the memory port
- `host_we`  in  1: host write enable
- `host_addr`  in  AW: host address
- `host_wdata`  in  DW: host write data
- `host_gnt`  out  1: host owns the memory port this cycle
- `host_rdata`  out  DW: memory read data to the host
- `core_we`, `core_addr`, `core_wdata`  in  1/AW/DW: core memory access
- `core_rdata`  out  DW: memory read data to the core
- `core_halt`  in  1: core done flag (Ack from the core decoder)
- `core_reset`  out  1: active-high reset to the core's PC, register file and memory
- `core_start`  out  1: one-cycle start pulse to the core's PC
- `mem_we`, `mem_addr`, `mem_wdata`  out  1/AW/DW: to the data memory
- `mem_rdata`  in  DW: asynchronous read data from the data memory
- `Done`  out  1: run finished; held until the next launch
- `Timeout`  out  1: run ended by the watchdog; held until the next launch
- `CycleCt`  out  CW: cycles spent in the last or current run

## Operation
- States: IDLE, LAUNCH, RUN, DONE.
- `start_q` registers `Start` every cycle. Launch event is `Start & ~start_q`.
- **IDLE** (the reset state):
  - `core_reset`=1, host owns the memory port.
  - On a launch event, go to LAUNCH.
- **LAUNCH** (exactly 1 cycle):
  - `core_reset`=0, `core_start`=1, core owns the port.
  - Clears `CycleCt`, `Done` and `Timeout`.
  - Always goes to RUN.
- **RUN**:
  - Core owns the port. `CycleCt` increments each cycle with `core_halt`=0 and saturates at all-ones.
  - `core_halt`=1: go to DONE, set `Done`=1.
  - With the watchdog: when `CycleCt`==TIMEOUT-1 and `core_halt`=0, go to DONE with `Done`=1 and `Timeout`=1.
  - If halt and the watchdog limit occur in the same cycle, halt wins and `Timeout` stays 0.
- **DONE**:
  - `core_reset`=0, so the core keeps its final state.
  - Host owns the port, which allows result readback.
  - On a launch event, go to LAUNCH.
- Launch events are ignored in LAUNCH and RUN. The edge detector still tracks `Start` in those states, so a level held across the end of a run does not retrigger.
- Memory mux:
  - In IDLE and DONE: `host_gnt` = `host_req`; `mem_we` = `host_req & host_we`; `mem_addr`/`mem_wdata` come from the host.
  - In LAUNCH and RUN: `host_gnt`=0; `mem_we` = `core_we` in RUN and 0 in LAUNCH; address and data come from the core.
  - A denied host request must be held by the host. The block does not queue it.
- `host_rdata` and `core_rdata` both equal `mem_rdata` (combinational pass-through).

## Timing
- Reset (`Reset_n`=0 at a posedge):
  - state=IDLE, `start_q`=0, `Done`=0, `Timeout`=0, `CycleCt`=0.
  - `core_reset`=1, `core_start`=0, `host_gnt` follows `host_req`.
- Reset mid-RUN aborts the run the next cycle. No `Done` is produced.
- `Start` rises in cycle n: LAUNCH in cycle n+1, RUN from n+2.
- `core_halt` is first seen high in cycle m of RUN: `Done`=1 and state=DONE from m+1. `CycleCt` is frozen at the number of halt-free RUN cycles.
- All outputs are registered or decoded from state, except the memory mux, `host_gnt` and the rdata paths, which are combinational.

## Configuration
- `RUN_CTRL_WATCHDOG_EN` defined: TIMEOUT comparison is compiled in and can end RUN with `Timeout`=1.
- Not defined: no comparator is built, `Timeout` is tied to 0, and RUN exits only on `core_halt`.

## Test plan
- Reset with `host_req`=1 and `host_addr`=8'h10: `core_reset`=1, `host_gnt`=1, `mem_addr`=8'h10, and `Done`/`Timeout`/`CycleCt` are all 0.
- Host writes 8'hA5 to 8'h20 in IDLE, then raises `Start`: `core_start` is high for exactly one cycle; `host_gnt`=0 during RUN even with `host_req`=1; `core_addr` reaches `mem_addr`.
- `core_halt` rises after 37 RUN cycles: `Done`=1 the next cycle, `CycleCt`=37, `Timeout`=0; host then reads 8'h20 with `host_gnt`=1.
- `Start` held high through the end of a run: no relaunch. Drop and re-raise `Start` in DONE: LAUNCH, `CycleCt` and `Done` cleared, and `core_reset` never asserted.
- Watchdog on, TIMEOUT=10, `core_halt` held 0: `Done`=1, `Timeout`=1, `CycleCt`=9. Repeat with `core_halt` rising in the 10th RUN cycle (`CycleCt`=9): `Timeout`=0.
- `Reset_n` pulsed low mid-RUN: next cycle state=IDLE, `core_reset`=1, `Done`=0.
